// File: rtl/nor_page_prog_seq_pkg.sv
// Shared definitions for the NOR page-program sequencer: NOR cycle codes,
// SPI command codes, sequencer state encodings and the bus address packer.
package nor_page_prog_seq_pkg;

    localparam logic [5:0] NOR_CYCLE_PROGRAM     = 6'h05;
    localparam logic [7:0] SPI_COMMAND_PAGE_PROG = 8'h02;

    // Width of the word-address field below the NOR cycle code in wb_adr_o.
    localparam int NOR_ADR_FIELD_W = 26;

    typedef enum logic [1:0] {
        PP_IDLE     = 2'd0,
        PP_FILL     = 2'd1,
        PP_ISSUE    = 2'd2,
        PP_WAIT_ACK = 2'd3
    } pp_state_e;

    // Pack the NOR cycle code above a word address into a Wishbone address.
    function automatic logic [31:0] nor_wb_adr(input logic [5:0] cycle,
                                               input logic [NOR_ADR_FIELD_W-1:0] word_adr);
        return {cycle, word_adr};
    endfunction

endpackage

// File: rtl/nor_page_prog_seq_if.sv
// Pipelined Wishbone write-side bus between the page-program sequencer and
// the NOR controller.
interface nor_page_prog_seq_if #(
    parameter int DATABITS = 16
);
    logic                wb_cyc_o;
    logic                wb_stb_o;
    logic                wb_we_o;
    logic [31:0]         wb_adr_o;
    logic [DATABITS-1:0] wb_dat_o;
    logic                wb_ack_i;
    logic                wb_err_i;
    logic                wb_stall_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        input  wb_ack_i, wb_err_i, wb_stall_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
        output wb_ack_i, wb_err_i, wb_stall_i
    );
endinterface

// File: rtl/nor_pp_word_buf.sv
// Page word buffer: synchronous write port, asynchronous read port, contents
// are not reset (the write count alone defines what is valid).
module nor_pp_word_buf #(
    parameter int DATABITS   = 16,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk_i,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATABITS-1:0]   wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATABITS-1:0]   rdata
);
    logic [DATABITS-1:0] mem [0:(1<<DEPTH_LOG2)-1];

    // Store one word per accepted strobe.
    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/nor_page_prog_seq.sv
// Buffers the words of one QSPI page-program transaction and, once CE rises,
// replays them as single Wishbone NOR program cycles at incrementing addresses.
module nor_page_prog_seq
    import nor_page_prog_seq_pkg::*;
#(
    parameter int ADDRBITS   = 26,
    parameter int DATABITS   = 16,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  pp_start_i,
    input  logic [ADDRBITS-1:0]   pp_addr_i,
    input  logic                  pp_wstb_i,
    input  logic [DATABITS-1:0]   pp_data_i,
    input  logic                  pp_commit_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  overflow_o,
    output logic                  err_o,
    output logic [DEPTH_LOG2:0]   count_o,
    nor_page_prog_seq_if.master   wb
);
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

    pp_state_e               state_q, state_d;
    logic [ADDRBITS-1:0]     base_q;
    logic [DEPTH_LOG2:0]     count_q;
    logic [DEPTH_LOG2-1:0]   rptr_q;
    logic                    overflow_q, err_q, done_q, cyc_q, stb_q;
    logic [31:0]             adr_q;
    logic [DATABITS-1:0]     dat_q;

    logic                    fill_active, fill_wr, fill_drop, fill_commit;
    logic [DEPTH_LOG2:0]     count_eff;
    logic                    last_word;
    logic [DEPTH_LOG2-1:0]   rd_addr;
    logic [DATABITS-1:0]     rd_data;
    logic [ADDRBITS-1:0]     word_adr;
    logic [31:0]             issue_adr;

    nor_pp_word_buf #(
        .DATABITS   (DATABITS),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_buf (
        .clk_i (clk_i),
        .we    (fill_wr),
        .waddr (count_q[DEPTH_LOG2-1:0]),
        .wdata (pp_data_i),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Decode FILL-phase events and the address/data of the word to issue next.
    always_comb begin
        fill_active = (state_q == PP_FILL) && !pp_start_i;
        fill_wr     = fill_active && pp_wstb_i && (count_q != DEPTH_CNT);
        fill_drop   = fill_active && pp_wstb_i && (count_q == DEPTH_CNT);
        fill_commit = fill_active && pp_commit_i;
        // A word strobed together with the commit is counted before the commit.
        count_eff   = count_q + {{DEPTH_LOG2{1'b0}}, fill_wr};
        last_word   = ({1'b0, rptr_q} == (count_q - (DEPTH_LOG2+1)'(1)));
        rd_addr     = (state_q == PP_FILL) ? '0 : rptr_q;
        word_adr    = base_q + ADDRBITS'(rd_addr);
        issue_adr   = nor_wb_adr(NOR_CYCLE_PROGRAM, NOR_ADR_FIELD_W'(word_adr));
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= PP_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PP_IDLE: begin
                if (pp_start_i) state_d = PP_FILL;
            end
            PP_FILL: begin
                if (pp_start_i)       state_d = PP_FILL;
                else if (pp_commit_i) state_d = (count_eff == '0) ? PP_IDLE : PP_ISSUE;
            end
            PP_ISSUE: begin
                if (cyc_q && stb_q && !wb.wb_stall_i) state_d = PP_WAIT_ACK;
            end
            PP_WAIT_ACK: begin
                if (wb.wb_err_i)      state_d = PP_IDLE;
                else if (wb.wb_ack_i) state_d = last_word ? PP_IDLE : PP_ISSUE;
            end
            default: state_d = PP_IDLE;
        endcase
    end

    // Outputs: everything comes straight from registers.
    always_comb begin
        busy_o        = (state_q == PP_ISSUE) || (state_q == PP_WAIT_ACK);
        done_o        = done_q;
        overflow_o    = overflow_q;
        err_o         = err_q;
        count_o       = count_q;
        wb.wb_cyc_o   = cyc_q;
        wb.wb_stb_o   = stb_q;
        wb.wb_we_o    = cyc_q;
        wb.wb_adr_o   = adr_q;
        wb.wb_dat_o   = dat_q;
    end

    // Page bookkeeping, flags and the registered Wishbone request.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            base_q     <= '0;
            count_q    <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                PP_IDLE, PP_FILL: begin
                    if (pp_start_i) begin
                        base_q     <= pp_addr_i;
                        count_q    <= '0;
                        rptr_q     <= '0;
                        overflow_q <= 1'b0;
                        err_q      <= 1'b0;
                    end else if (state_q == PP_FILL) begin
                        count_q <= count_eff;
                        if (fill_drop) overflow_q <= 1'b1;
                        if (fill_commit) begin
                            if (count_eff == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                rptr_q <= '0;
                                cyc_q  <= 1'b1;
                                stb_q  <= 1'b1;
                                adr_q  <= issue_adr;
                                // Word 0 may be arriving on this very edge.
                                dat_q  <= (fill_wr && count_q == '0) ? pp_data_i : rd_data;
                            end
                        end
                    end
                end
                PP_ISSUE: begin
                    if (!cyc_q) begin
                        cyc_q <= 1'b1;
                        stb_q <= 1'b1;
                        adr_q <= issue_adr;
                        dat_q <= rd_data;
                    end else if (stb_q && !wb.wb_stall_i) begin
                        stb_q <= 1'b0;
                    end
                end
                PP_WAIT_ACK: begin
                    if (wb.wb_err_i) begin
                        err_q  <= 1'b1;
                        cyc_q  <= 1'b0;
                        done_q <= 1'b1;
                    end else if (wb.wb_ack_i) begin
                        cyc_q <= 1'b0;
                        if (last_word) done_q <= 1'b1;
                        else           rptr_q <= rptr_q + DEPTH_LOG2'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_nor_page_prog_seq.sv
// Bench for nor_page_prog_seq: vector table of page programs plus hand-written
// stall/error, mid-sequence reset and same-cycle commit sequences.
module tb_nor_page_prog_seq;
    import nor_page_prog_seq_pkg::*;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        pp_start_i = 1'b0;
    logic [25:0] pp_addr_i = '0;
    logic        pp_wstb_i = 1'b0;
    logic [15:0] pp_data_i = '0;
    logic        pp_commit_i = 1'b0;
    logic        busy_o, done_o, overflow_o, err_o;
    logic [5:0]  count_o;

    nor_page_prog_seq_if #(.DATABITS(16)) wb ();

    nor_page_prog_seq #(.ADDRBITS(26), .DATABITS(16), .DEPTH_LOG2(5)) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .pp_start_i  (pp_start_i),
        .pp_addr_i   (pp_addr_i),
        .pp_wstb_i   (pp_wstb_i),
        .pp_data_i   (pp_data_i),
        .pp_commit_i (pp_commit_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o),
        .err_o       (err_o),
        .count_o     (count_o),
        .wb          (wb)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] adr;
        logic [15:0] dat;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [25:0] base;
        int          nwords;
        logic [15:0] seed;
        int          lat;
        bit          same;
        int          exp_cyc;
        bit          exp_ovf;
        int          exp_cnt;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave model / monitor state.
    int          ack_lat = 1;
    int          stall_left = 0;
    int          err_idx = -1;
    int          req_idx = 0;
    int          acc_cnt = 0;
    int          done_cnt = 0;
    int          cyc_hi_cnt = 0;
    int          gap = 0;
    bit          pend = 0;
    bit          pend_err = 0;
    int          pend_wait = 0;
    bit          prev_req = 0;
    logic [31:0] prev_adr;
    logic [15:0] prev_dat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        wb.wb_ack_i   = 1'b0;
        wb.wb_err_i   = 1'b0;
        wb.wb_stall_i = 1'b0;
    end

    // Wishbone slave responder and bus monitor, all decisions at the falling edge.
    always @(negedge clk_i) begin
        wb.wb_ack_i = 1'b0;
        wb.wb_err_i = 1'b0;
        if (reset_i) begin
            pend = 0;
        end else if (pend) begin
            if (pend_wait <= 1) begin
                if (pend_err) wb.wb_err_i = 1'b1;
                else          wb.wb_ack_i = 1'b1;
                pend = 0;
            end else begin
                pend_wait--;
            end
        end

        if (wb.wb_cyc_o) cyc_hi_cnt++;
        if (done_o) done_cnt++;

        if (!busy_o) gap = 0;
        else if (!wb.wb_cyc_o) gap++;
        else if (gap > 0) begin
            check("idle_gap", 64'(gap), 64'd1);
            gap = 0;
        end

        if (wb.wb_cyc_o && wb.wb_stb_o) begin
            check("we_with_cyc", 64'(wb.wb_we_o), 64'd1);
            if (prev_req) begin
                check("stall_adr_stable", 64'(wb.wb_adr_o), 64'(prev_adr));
                check("stall_dat_stable", 64'(wb.wb_dat_o), 64'(prev_dat));
            end
            if (stall_left > 0) begin
                wb.wb_stall_i = 1'b1;
                stall_left--;
                prev_req = 1;
                prev_adr = wb.wb_adr_o;
                prev_dat = wb.wb_dat_o;
            end else begin
                wb.wb_stall_i = 1'b0;
                prev_req = 0;
                acc_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_bus_cycle", 64'(wb.wb_adr_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("bus_adr", 64'(wb.wb_adr_o), 64'(e.adr));
                    check("bus_dat", 64'(wb.wb_dat_o), 64'(e.dat));
                end
                pend      = 1;
                pend_wait = ack_lat;
                pend_err  = (req_idx == err_idx);
                req_idx++;
            end
        end else begin
            wb.wb_stall_i = 1'b0;
            prev_req = 0;
        end
    end

    // Start a page, strobe words (pushing their expected bus cycles), commit,
    // then check the first request appears one cycle after the commit.
    task automatic issue_page(input logic [25:0] base, input int n, input logic [15:0] seed,
                              input int lat, input bit same, input int stall, input int erri);
        ack_lat    = lat;
        stall_left = stall;
        err_idx    = erri;
        req_idx    = 0;
        acc_cnt    = 0;
        done_cnt   = 0;
        cyc_hi_cnt = 0;
        @(negedge clk_i);
        pp_start_i = 1'b1;
        pp_addr_i  = base;
        @(negedge clk_i);
        pp_start_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic [25:0] a;
            exp_t e;
            pp_wstb_i = 1'b1;
            pp_data_i = seed + 16'(i);
            if (same && i == n - 1) pp_commit_i = 1'b1;
            if (i < 32) begin
                a = base + 26'(i);
                e.adr = {NOR_CYCLE_PROGRAM, a};
                e.dat = pp_data_i;
                exp_q.push_back(e);
            end
            @(negedge clk_i);
            pp_wstb_i   = 1'b0;
            pp_commit_i = 1'b0;
        end
        if (!(same && n > 0)) begin
            pp_commit_i = 1'b1;
            @(negedge clk_i);
            pp_commit_i = 1'b0;
        end
        check("first_req_latency", 64'(wb.wb_cyc_o), 64'(n > 0));
        if (n == 0) check("empty_done_next_cycle", 64'(done_o), 64'd1);
    endtask

    // Wait (bounded) for the sequence to end and check the page summary.
    task automatic finish_page(input int exp_cyc, input bit exp_ovf, input bit exp_err,
                               input int exp_cnt, input int exp_left);
        for (int k = 0; k < 3000 && done_cnt == 0; k++) @(negedge clk_i);
        check("done_seen", 64'(done_cnt > 0), 64'd1);
        repeat (4) @(negedge clk_i);
        check("done_once", 64'(done_cnt), 64'd1);
        check("bus_cycles", 64'(acc_cnt), 64'(exp_cyc));
        check("busy_after", 64'(busy_o), 64'd0);
        check("cyc_after", 64'(wb.wb_cyc_o), 64'd0);
        check("overflow", 64'(overflow_o), 64'(exp_ovf));
        check("err", 64'(err_o), 64'(exp_err));
        check("count", 64'(count_o), 64'(exp_cnt));
        check("leftover_words", 64'(exp_q.size()), 64'(exp_left));
        if (exp_cyc == 0) check("cyc_never", 64'(cyc_hi_cnt), 64'd0);
        exp_q.delete();
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{26'h0000100, 4,  16'hA001, 2, 1'b0, 4,  1'b0, 4};
        vecs[1] = '{26'h3FFFFFE, 3,  16'h1234, 1, 1'b0, 3,  1'b0, 3};
        vecs[2] = '{26'h0000200, 33, 16'h5000, 1, 1'b0, 32, 1'b1, 32};
        vecs[3] = '{26'h0000300, 0,  16'h0000, 1, 1'b0, 0,  1'b0, 0};
        vecs[4] = '{26'h2ABCDEF, 1,  16'h7E57, 3, 1'b0, 1,  1'b0, 1};

        // Reset state.
        repeat (2) @(negedge clk_i);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_ovf", 64'(overflow_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_cyc", 64'(wb.wb_cyc_o), 64'd0);
        check("rst_stb", 64'(wb.wb_stb_o), 64'd0);
        check("rst_adr", 64'(wb.wb_adr_o), 64'd0);
        check("rst_dat", 64'(wb.wb_dat_o), 64'd0);
        reset_i = 1'b0;

        for (int v = 0; v < 5; v++) begin
            issue_page(vecs[v].base, vecs[v].nwords, vecs[v].seed, vecs[v].lat, vecs[v].same, 0, -1);
            finish_page(vecs[v].exp_cyc, vecs[v].exp_ovf, 1'b0, vecs[v].exp_cnt, 0);
        end

        // Stall 5 cycles on the first request, then an error on word 2 of 4.
        issue_page(26'h0000800, 4, 16'hB000, 2, 1'b0, 5, 1);
        finish_page(2, 1'b0, 1'b1, 4, 2);
        repeat (10) @(negedge clk_i);
        check("no_cycles_after_err", 64'(acc_cnt), 64'd2);

        // Same-cycle last strobe and commit; also clears the sticky error.
        issue_page(26'h0000900, 2, 16'hD000, 1, 1'b1, 0, -1);
        finish_page(2, 1'b0, 1'b0, 2, 0);

        // Reset while waiting for the ack of word 1.
        issue_page(26'h0000040, 3, 16'hC000, 20, 1'b0, 0, -1);
        for (int k = 0; k < 100 && acc_cnt == 0; k++) @(negedge clk_i);
        check("reset_seq_accepted", 64'(acc_cnt), 64'd1);
        repeat (2) @(negedge clk_i);
        check("reset_seq_busy_before", 64'(busy_o), 64'd1);
        reset_i = 1'b1;
        @(negedge clk_i);
        check("reset_mid_cyc", 64'(wb.wb_cyc_o), 64'd0);
        check("reset_mid_busy", 64'(busy_o), 64'd0);
        check("reset_mid_count", 64'(count_o), 64'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        exp_q.delete();

        // Clean page after reset: single word strobed with the commit.
        issue_page(26'h0000A00, 1, 16'hE00F, 1, 1'b1, 0, -1);
        finish_page(1, 1'b0, 1'b0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the bench can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/nor_page_prog_seq.md
Name: nor_page_prog_seq

Overview:
- Page-program sequencer between the QSPI command FSM and the NOR Wishbone controller.
- Buffers the data words of one QSPI page-program transaction while CE is low.
- After CE deasserts, issues one Wishbone NOR program cycle per buffered word at incrementing addresses.
- Serialises the whole page onto the single NOR bus and reports completion, overflow and bus error.

Parameters:
ADDRBITS, 26, NOR word-address width
DATABITS, 16, NOR data word width
DEPTH_LOG2, 5, log2 of buffer depth (DEPTH = 32 words)

Ports:
clk_i  in  1  system clock
reset_i  in  1  synchronous, active-high reset
pp_start_i  in  1  one-cycle pulse: new page; latch pp_addr_i as base, clear buffer
pp_addr_i  in  ADDRBITS  base word address, valid with pp_start_i
pp_wstb_i  in  1  one-cycle pulse: pp_data_i valid
pp_data_i  in  DATABITS  data word
pp_commit_i  in  1  one-cycle pulse on CE deassert: begin programming
busy_o  out  1  high in ISSUE/WAIT_ACK
done_o  out  1  one-cycle pulse on sequence end
overflow_o  out  1  sticky: word dropped because buffer full; cleared by pp_start_i
err_o  out  1  sticky: wb_err_i seen; cleared by pp_start_i
count_o  out  DEPTH_LOG2+1  words currently buffered
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  always 1 while wb_cyc_o is high
wb_adr_o  out  32  {NOR_CYCLE_PROGRAM[5:0], word address}
wb_dat_o  out  DATABITS  write data
wb_ack_i  in  1  Wishbone ack
wb_err_i  in  1  Wishbone error
wb_stall_i  in  1  pipelined stall

Behaviour:
- Reset values (next edge after reset_i): state IDLE, all outputs 0. Mid-sequence reset drops wb_cyc_o/wb_stb_o at that edge and discards the buffer.
- States: IDLE, FILL, ISSUE, WAIT_ACK.
- IDLE: pp_start_i -> FILL. Latches base, count<=0, clears overflow_o/err_o. pp_wstb_i and pp_commit_i are ignored.
- FILL, pp_wstb_i with count<DEPTH: mem[count]<=pp_data_i, count++.
- FILL, pp_wstb_i with count==DEPTH: word dropped, overflow_o<=1.
- FILL, pp_wstb_i and pp_commit_i in the same cycle: the word is accepted first, then the commit is processed.
- FILL, pp_commit_i with resulting count==0: -> IDLE, done_o pulses next cycle, no bus activity.
- FILL, pp_commit_i with count>0: -> ISSUE, rptr<=0.
- FILL, pp_start_i: restart. Base is re-latched, count<=0, flags cleared. pp_start_i takes priority over pp_wstb_i/pp_commit_i.
- ISSUE: wb_cyc_o=wb_stb_o=1, wb_we_o=1, wb_adr_o={NOR_CYCLE_PROGRAM, base+rptr} (sum modulo 2^ADDRBITS), wb_dat_o=mem[rptr]. Any bits between ADDRBITS and bit 26 are zero. Address and data are registered, stable while stalled.
- ISSUE to WAIT_ACK: taken on the first cycle with !wb_stall_i. wb_stb_o<=0, wb_cyc_o stays 1.
- First request latency: wb_cyc_o rises on the cycle after pp_commit_i.
- WAIT_ACK, wb_err_i (takes priority over wb_ack_i): err_o<=1, remaining words abandoned, wb_cyc_o<=0, -> IDLE, done_o pulses.
- WAIT_ACK, wb_ack_i with rptr==count-1: wb_cyc_o<=0, -> IDLE, done_o pulses.
- WAIT_ACK, wb_ack_i otherwise: wb_cyc_o<=0 for exactly one cycle, rptr++, then ISSUE.
- ack/err outside WAIT_ACK is ignored. An ack arriving in the same cycle the stall releases is ignored.
- While busy_o: pp_start_i, pp_wstb_i and pp_commit_i are ignored. count_o holds the buffered count until the next pp_start_i.
- No timeout; WAIT_ACK waits indefinitely for ack/err.

Decomposition:
- cmd_defs.vh: NOR_CYCLE_PROGRAM and SPI_COMMAND_PAGE_PROG (existing). Add PP state encodings as shared localparams for the bench monitor.
- Sub-module nor_pp_word_buf: DEPTH x DATABITS buffer, one synchronous write port, one asynchronous read port. No reset on contents.

Test Plan:
1. Start addr=0x0000100, 4 words 0xA001..0xA004, commit, ack 2 cycles after each stb -> 4 cycles, addresses 0x100..0x103 with cmd field NOR_CYCLE_PROGRAM, matching data; one idle cycle between cycles; done_o once; err_o=0.
2. Start, commit with no words -> done_o next cycle; wb_cyc_o never asserted.
3. 33 strobes, DEPTH=32 -> overflow_o=1, count_o=32, exactly 32 bus cycles, last data = word 32.
4. Base 0x3FFFFFE, 3 words -> addresses 0x3FFFFFE, 0x3FFFFFF, 0x0000000.
5. wb_stall_i held 5 cycles on the first request -> wb_adr_o/wb_dat_o stable, single stb accepted; wb_err_i on word 2 of 4 -> err_o=1, no further cycles, done_o pulse.
6. reset_i during WAIT_ACK of word 1 -> wb_cyc_o=0 next edge, busy_o=0; a new start then runs cleanly. Same-cycle wstb+commit -> word is included.
